imem_load_ctrl: RTL

//  Owns the LC2K instruction memory and shares it between a program-load stream and CPU fetch.

---
 rtl/lc2k_pkg.sv | 29 ++
 rtl/imem_load_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/lc2k_pkg.sv
// Shared LC2K definitions: controller state encodings, special instruction words,
// and the opcode field layout of a 32-bit LC2K instruction.
package lc2k_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;
  localparam logic [1:0] ST_RUN  = 2'd3;

  localparam logic [31:0] HALT_W = 32'd25165824;
  localparam logic [31:0] NOOP_W = 32'd29360128;

  localparam int OPCODE_LSB = 22;
  localparam int OPCODE_W   = 3;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_NOR  = 3'd1;
  localparam logic [2:0] OP_LW   = 3'd2;
  localparam logic [2:0] OP_SW   = 3'd3;
  localparam logic [2:0] OP_BEQ  = 3'd4;
  localparam logic [2:0] OP_JALR = 3'd5;
  localparam logic [2:0] OP_HALT = 3'd6;
  localparam logic [2:0] OP_NOOP = 3'd7;

  function automatic logic [2:0] opcode_of(input logic [31:0] word);
    return word[OPCODE_LSB +: OPCODE_W];
  endfunction

endpackage

// File: rtl/imem_load_ctrl.sv
// Instruction-memory owner for an LC2K core: streams a program in after reset,
// pads the rest of memory with HALT, then hands fetch over to the CPU.
module imem_load_ctrl
  import lc2k_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic [31:0]       pcCurrent,
  output logic [31:0]       instr,
  output logic              cpu_stall,
  output logic              load_done,
  output logic              load_ovf,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [31:0]       mem_rdata
);

  // One extra pointer bit so the pointer can sit at DEPTH once memory is full.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

  logic [1:0]      state_q, state_d;
  logic [ADDR_W:0] wptr_q, wptr_d;
  logic            ovf_pending_q, ovf_pending_d;
  logic            load_ovf_q, load_ovf_d;
  logic            load_done_q;
  logic            we_c;
  logic            pc_in_range;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d       = state_q;
    wptr_d        = wptr_q;
    ovf_pending_d = ovf_pending_q;
    load_ovf_d    = load_ovf_q;
    we_c          = 1'b0;
    mem_waddr     = wptr_q[ADDR_W-1:0];
    mem_wdata     = HALT_W;

    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (load_start) begin
          state_d       = ST_LOAD;
          wptr_d        = '0;
          ovf_pending_d = 1'b0;
          load_ovf_d    = 1'b0;
        end
      end

      ST_LOAD: begin
        if (load_valid) begin
          if (ovf_pending_q) begin
            // Memory is already full: drain the stream without writing.
            load_ovf_d = 1'b1;
            if (load_last) state_d = ST_RUN;
          end else begin
            we_c      = 1'b1;
            mem_wdata = load_data;
            wptr_d    = wptr_q + PTR_ONE;
            if (wptr_q == LAST_IDX) begin
              if (load_last) state_d = ST_RUN;
              else           ovf_pending_d = 1'b1;
            end else if (load_last) begin
              state_d = ST_FILL;
            end
          end
        end
      end

      ST_FILL: begin
        if (wptr_q > LAST_IDX) begin
          state_d = ST_RUN;
        end else begin
          we_c   = 1'b1;
          wptr_d = wptr_q + PTR_ONE;
          if (wptr_q == LAST_IDX) state_d = ST_RUN;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q       <= ST_IDLE;
      wptr_q        <= '0;
      ovf_pending_q <= 1'b0;
      load_ovf_q    <= 1'b0;
      load_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      ovf_pending_q <= ovf_pending_d;
      load_ovf_q    <= load_ovf_d;
      load_done_q   <= (state_d == ST_RUN) && (state_q != ST_RUN);
    end
  end

  // A reset landing mid-load must not leave a stray write behind.
  assign mem_we      = we_c & ~reset;
  assign load_ready  = (state_q == ST_LOAD);
  assign cpu_stall   = (state_q != ST_RUN);
  assign load_done   = load_done_q;
  assign load_ovf    = load_ovf_q;
  assign mem_raddr   = pcCurrent[ADDR_W-1:0];
  assign pc_in_range = ((pcCurrent >> ADDR_W) == '0);
  assign instr       = (state_q == ST_RUN && pc_in_range) ? mem_rdata : HALT_W;

endmodule
